// File: rtl/alu.sv
// Registered 32-bit RV32 execute-stage ALU.
// Result and {ZF, SF, CF, OF} flags appear one clock after the operands.
module alu (
    input  logic [31:0] lhs,
    input  logic [31:0] rhs,
    input  logic        clk,
    input  logic [3:0]  op,
    output logic [31:0] res,
    output logic [3:0]  flags,
    input  logic        rst_n
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_ADDU = 4'b1010;
    localparam logic [3:0] OP_SUBU = 4'b1011;

    logic [31:0] res_d, res_q;
    logic [3:0]  flags_d, flags_q;
    logic [32:0] sum;
    logic [32:0] diff;
    logic [4:0]  shamt;
    logic        cf, of;

    // bit 32 of the widened sum is the carry; of the difference, the borrow
    assign sum   = {1'b0, lhs} + {1'b0, rhs};
    assign diff  = {1'b0, lhs} - {1'b0, rhs};
    assign shamt = rhs[4:0];

    always_comb begin
        res_d = 32'h0;
        cf    = 1'b0;
        of    = 1'b0;
        unique case (op)
            OP_ADD: begin
                res_d = sum[31:0];
                cf    = sum[32];
                of    = (lhs[31] == rhs[31]) && (sum[31] != lhs[31]);
            end
            OP_SLL:  res_d = lhs << shamt;
            OP_SLT:  res_d = {31'b0, $signed(lhs) < $signed(rhs)};
            OP_SLTU: res_d = {31'b0, lhs < rhs};
            OP_XOR:  res_d = lhs ^ rhs;
            OP_SRL:  res_d = lhs >> shamt;
            OP_OR:   res_d = lhs | rhs;
            OP_AND:  res_d = lhs & rhs;
            OP_SUB: begin
                res_d = diff[31:0];
                cf    = diff[32];
                of    = (lhs[31] != rhs[31]) && (diff[31] != lhs[31]);
            end
            OP_SRA:  res_d = $unsigned($signed(lhs) >>> shamt);
            OP_ADDU: begin
                res_d = sum[31:0];
                cf    = sum[32];
            end
            OP_SUBU: begin
                res_d = diff[31:0];
                cf    = diff[32];
            end
            default: res_d = 32'h0;
        endcase
        flags_d = {res_d == 32'h0, res_d[31], cf, of};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= 32'h0;
            flags_q <= 4'b0000;
        end else begin
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    assign res   = res_q;
    assign flags = flags_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for the registered ALU: directed vectors with
// hand-computed results; a monitor pops expectations each clock.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] lhs, rhs;
    logic [3:0]  op;
    logic [31:0] res;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [3:0]  f;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] r;
        logic [3:0]  f;
    } exp_t;

    exp_t sb[$];

    alu dut (
        .lhs   (lhs),
        .rhs   (rhs),
        .clk   (clk),
        .op    (op),
        .res   (res),
        .flags (flags),
        .rst_n (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string nm, input logic [31:0] act,
                             input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // monitor: every clock, the oldest issued op must be on the outputs
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_val({e.name, " res"}, res, e.r);
                check_val({e.name, " flags"}, {28'h0, flags}, {28'h0, e.f});
            end
        end
    end

    vec_t vecs[] = '{
        '{"add_wrap",  4'b0000, 32'hffffffff, 32'h00000001, 32'h00000000, 4'b1010},
        '{"add_ovf",   4'b0000, 32'h7fffffff, 32'h10000003, 32'h90000002, 4'b0101},
        '{"sll",       4'b0001, 32'h000f0000, 32'h00000002, 32'h003c0000, 4'b0000},
        '{"sll_hi",    4'b0001, 32'h00000003, 32'hffffffe1, 32'h00000006, 4'b0000},
        '{"slt_t",     4'b0010, 32'hffff0000, 32'h00030001, 32'h00000001, 4'b0000},
        '{"slt_f",     4'b0010, 32'h0fffffff, 32'h00090003, 32'h00000000, 4'b1000},
        '{"sltu_f",    4'b0011, 32'hf0000000, 32'h00000001, 32'h00000000, 4'b1000},
        '{"sltu_t",    4'b0011, 32'h00000001, 32'hf0000000, 32'h00000001, 4'b0000},
        '{"xor",       4'b0100, 32'h00000000, 32'h00000001, 32'h00000001, 4'b0000},
        '{"srl",       4'b0101, 32'h80000000, 32'h00000024, 32'h08000000, 4'b0000},
        '{"or",        4'b0110, 32'h00000000, 32'h00000001, 32'h00000001, 4'b0000},
        '{"and",       4'b0111, 32'h0d000001, 32'h0f000001, 32'h0d000001, 4'b0000},
        '{"sub_ovf",   4'b1000, 32'h80000000, 32'h0fffffff, 32'h70000001, 4'b0001},
        '{"sub_brw",   4'b1000, 32'h00000001, 32'h00000002, 32'hffffffff, 4'b0110},
        '{"sra_pos",   4'b1001, 32'h000000f0, 32'h00000001, 32'h00000078, 4'b0000},
        '{"sra_neg",   4'b1001, 32'hffffffff, 32'h00000003, 32'hffffffff, 4'b0100},
        '{"sra_sgn",   4'b1001, 32'h80000000, 32'h00000004, 32'hf8000000, 4'b0100},
        '{"addu",      4'b1010, 32'h00000000, 32'h00000001, 32'h00000001, 4'b0000},
        '{"addu_wrap", 4'b1010, 32'hffffffff, 32'h00000001, 32'h00000000, 4'b1010},
        '{"addu_novf", 4'b1010, 32'h7fffffff, 32'h00000001, 32'h80000000, 4'b0100},
        '{"subu_brw",  4'b1011, 32'h00000000, 32'h00000001, 32'hffffffff, 4'b0110},
        '{"op_1111",   4'b1111, 32'h12345678, 32'h9abcdef0, 32'h00000000, 4'b1000},
        '{"op_1100",   4'b1100, 32'hffffffff, 32'hffffffff, 32'h00000000, 4'b1000},
        '{"subu",      4'b1011, 32'h7fffffff, 32'h70000001, 32'h0ffffffe, 4'b0000}
    };

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #2;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s drain: %0d results outstanding, expected 0",
                     nm, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0;
        lhs   = 32'h0;
        rhs   = 32'h0;
        op    = 4'b0000;
        #2;
        check_val("reset res", res, 32'h0);
        check_val("reset flags", {28'h0, flags}, 32'h0);
        lhs = 32'h00000005;
        rhs = 32'h00000007;
        @(posedge clk);
        #1;
        check_val("reset held res", res, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            lhs    = vecs[i].a;
            rhs    = vecs[i].b;
            op     = vecs[i].op;
            e.name = vecs[i].name;
            e.r    = vecs[i].r;
            e.f    = vecs[i].f;
            sb.push_back(e);
        end
        drain("vectors");

        // inputs changing mid-cycle must not reach the outputs
        @(negedge clk);
        lhs = 32'h00000001;
        rhs = 32'h00000001;
        op  = 4'b0000;
        #1;
        check_val("hold res", res, 32'h0ffffffe);

        // async reset pulse between edges drops the in-flight 1+1
        #1;
        rst_n = 1'b0;
        #1;
        check_val("async rst res", res, 32'h0);
        check_val("async rst flags", {28'h0, flags}, 32'h0);
        @(posedge clk);
        #1;
        check_val("rst edge res", res, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        lhs   = 32'h00000002;
        rhs   = 32'h00000003;
        op    = 4'b0000;
        e.name = "post_rst";
        e.r    = 32'h00000005;
        e.f    = 4'b0000;
        sb.push_back(e);
        drain("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
